sm4_cmd_sched: RTL and testbench

- Command sequencer in front of the SM4 core (`sm4_top`). Accepts a serial stream of LOAD_KEY / ENCRYPT / DECRYPT commands over valid/ready.
- Drives the core's key-expansion and enc/dec handshakes, and returns one response per command over valid/ready.
- Caches the user key and the direction of the currently expanded key schedule. When a block's direction differs from it, the block re-expands the key automatically before processing.

---
 rtl/sm4_pkg.sv | 28 ++
 rtl/sm4_cmd_sched.sv | 202 ++++++++++++++++++++
 tb/tb_sm4_cmd_sched.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sm4_pkg.sv
// Shared encodings for the SM4 command sequencer: command opcodes,
// key-schedule directions and the sequencer FSM state enum.
package sm4_pkg;

    localparam logic [1:0] OP_LOAD_KEY = 2'b00;
    localparam logic [1:0] OP_ENC      = 2'b01;
    localparam logic [1:0] OP_DEC      = 2'b10;
    localparam logic [1:0] OP_RSVD     = 2'b11;

    localparam logic DIR_ENC = 1'b0;
    localparam logic DIR_DEC = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_KEY_ISSUE = 3'd1,
        ST_KEY_WAIT  = 3'd2,
        ST_BLK_ISSUE = 3'd3,
        ST_BLK_WAIT  = 3'd4,
        ST_RESP      = 3'd5,
        ST_FLUSH     = 3'd6
    } state_e;

    // Key-schedule direction a block command needs (DECRYPT -> dec schedule).
    function automatic logic op_dir(input logic [1:0] op);
        return (op == OP_DEC) ? DIR_DEC : DIR_ENC;
    endfunction

endpackage

// File: rtl/sm4_cmd_sched.sv
// SM4 command sequencer: takes LOAD_KEY / ENCRYPT / DECRYPT commands, drives
// the SM4 core key-expansion and block handshakes, returns one response per
// command. Caches the key and the direction of the expanded schedule and
// re-expands automatically when a block needs the other direction.
//
// Optional build macro: SM4_CMD_SCHED_WDOG_EN adds a watchdog that aborts a
// stuck KEY_WAIT/BLK_WAIT after TIMEOUT_CYCLES cycles via a FLUSH state.
//
// Handshakes: a command transfers on a cycle where cmd_valid_in and
// cmd_ready_out are both 1; a response transfers on a cycle where
// rsp_valid_out and rsp_ready_in are both 1. Once rsp_valid_out rises, the
// response data and error stay stable until that transfer happens.
// fsm_state_out exposes the FSM state (sm4_pkg::state_e encoding).
module sm4_cmd_sched
    import sm4_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         cmd_valid_in,
    output logic         cmd_ready_out,
    input  logic [1:0]   cmd_op_in,
    input  logic [127:0] cmd_data_in,
    output logic         rsp_valid_out,
    input  logic         rsp_ready_in,
    output logic [127:0] rsp_data_out,
    output logic         rsp_err_out,
    output logic         key_loaded_out,
    output logic         busy_out,
    output logic         sm4_enable_out,
    output logic         encdec_sel_out,
    output logic         enable_key_exp_out,
    output logic         user_key_valid_out,
    output logic [127:0] user_key_out,
    input  logic         key_exp_ready_in,
    output logic         encdec_enable_out,
    output logic         valid_out,
    output logic [127:0] data_out,
    input  logic         ready_in,
    input  logic [127:0] result_in,
    output logic [2:0]   fsm_state_out
);

    state_e       state, state_next;
    logic         out_en;      // 0 while in reset, 1 afterwards
    logic [127:0] key_reg;
    logic         key_loaded;
    logic         key_mode;    // direction of the currently expanded schedule
    logic         tgt_sel;     // direction being expanded in KEY states
    logic         pend_load;   // current command is LOAD_KEY
    logic [127:0] blk_reg;
    logic [127:0] rsp_data;
    logic         rsp_err;
    logic         wait_first;  // first cycle of a WAIT state: core ready is stale
    logic         cmd_accept;
    logic         key_done;
    logic         blk_done;
    logic         wd_hit;

    assign cmd_accept = cmd_valid_in && cmd_ready_out;
    assign key_done   = (state == ST_KEY_WAIT) && !wait_first && key_exp_ready_in;
    assign blk_done   = (state == ST_BLK_WAIT) && !wait_first && ready_in;

`ifdef SM4_CMD_SCHED_WDOG_EN
    logic [TO_W-1:0] wd_cnt;

    // The last permitted wait cycle is the one where the count shows
    // TIMEOUT_CYCLES-1; the counter itself reaches TIMEOUT_CYCLES there.
    assign wd_hit = ((state == ST_KEY_WAIT) || (state == ST_BLK_WAIT)) &&
                    (wd_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: cleared while issuing, counts every cycle spent waiting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt <= '0;
        end else if ((state == ST_KEY_ISSUE) || (state == ST_BLK_ISSUE)) begin
            wd_cnt <= '0;
        end else if ((state == ST_KEY_WAIT) || (state == ST_BLK_WAIT)) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    logic [TO_W-1:0] unused_wd;

    assign wd_hit    = 1'b0;
    assign unused_wd = '0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Next-state logic; a completed wait wins over a same-cycle timeout.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (cmd_accept) begin
                    if (cmd_op_in == OP_LOAD_KEY)                    state_next = ST_KEY_ISSUE;
                    else if ((cmd_op_in == OP_RSVD) || !key_loaded) state_next = ST_RESP;
                    else if (key_mode == op_dir(cmd_op_in))         state_next = ST_BLK_ISSUE;
                    else                                            state_next = ST_KEY_ISSUE;
                end
            end
            ST_KEY_ISSUE: state_next = ST_KEY_WAIT;
            ST_KEY_WAIT: begin
                if (key_done)    state_next = pend_load ? ST_RESP : ST_BLK_ISSUE;
                else if (wd_hit) state_next = ST_FLUSH;
            end
            ST_BLK_ISSUE: state_next = ST_BLK_WAIT;
            ST_BLK_WAIT: begin
                if (blk_done)    state_next = ST_RESP;
                else if (wd_hit) state_next = ST_FLUSH;
            end
            ST_RESP:  if (rsp_ready_in) state_next = ST_IDLE;
            ST_FLUSH: state_next = ST_RESP;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Command latch, key cache and response registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_en     <= 1'b0;
            key_reg    <= '0;
            key_loaded <= 1'b0;
            key_mode   <= DIR_ENC;
            tgt_sel    <= DIR_ENC;
            pend_load  <= 1'b0;
            blk_reg    <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            wait_first <= 1'b0;
        end else begin
            out_en     <= 1'b1;
            wait_first <= (state == ST_KEY_ISSUE) || (state == ST_BLK_ISSUE);
            case (state)
                ST_IDLE: begin
                    if (cmd_accept) begin
                        pend_load <= (cmd_op_in == OP_LOAD_KEY);
                        blk_reg   <= cmd_data_in;
                        if (cmd_op_in == OP_LOAD_KEY) begin
                            key_reg    <= cmd_data_in;
                            key_loaded <= 1'b0;
                            tgt_sel    <= DIR_ENC;
                        end else if ((cmd_op_in == OP_RSVD) || !key_loaded) begin
                            rsp_err  <= 1'b1;
                            rsp_data <= '0;
                        end else begin
                            tgt_sel <= op_dir(cmd_op_in);
                        end
                    end
                end
                ST_KEY_WAIT: begin
                    if (key_done) begin
                        key_loaded <= 1'b1;
                        key_mode   <= tgt_sel;
                        rsp_err    <= 1'b0;
                        rsp_data   <= '0;
                    end
                end
                ST_BLK_WAIT: begin
                    if (blk_done) begin
                        rsp_data <= result_in;
                        rsp_err  <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    key_loaded <= 1'b0;
                    rsp_err    <= 1'b1;
                    rsp_data   <= '0;
                end
                default: ;
            endcase
        end
    end

    // Core-side strobes and command/response flags decoded from the state.
    always_comb begin
        cmd_ready_out      = out_en && (state == ST_IDLE);
        rsp_valid_out      = (state == ST_RESP);
        busy_out           = (state != ST_IDLE);
        sm4_enable_out     = out_en && (state != ST_FLUSH);
        enable_key_exp_out = (state == ST_KEY_ISSUE) || (state == ST_KEY_WAIT);
        user_key_valid_out = (state == ST_KEY_ISSUE);
        encdec_enable_out  = (state == ST_BLK_ISSUE) || (state == ST_BLK_WAIT);
        valid_out          = (state == ST_BLK_ISSUE);
        data_out           = (state == ST_BLK_ISSUE) ? blk_reg : '0;
        encdec_sel_out     = enable_key_exp_out ? tgt_sel : key_mode;
    end

    assign rsp_data_out   = rsp_data;
    assign rsp_err_out    = rsp_err;
    assign key_loaded_out = key_loaded;
    assign user_key_out   = key_reg;
    assign fsm_state_out  = state;

endmodule

// File: tb/tb_sm4_cmd_sched.sv
// Bench for sm4_cmd_sched: a behavioural SM4 core model answers the key and
// block handshakes; expected responses go into exp_q as each command is
// driven and are popped when the response handshake completes.
module tb_sm4_cmd_sched;
  import sm4_pkg::*;

`ifdef SM4_CMD_SCHED_WDOG_EN
  localparam int TB_TO = 16;
`else
  localparam int TB_TO = 1024;
`endif
  localparam logic [127:0] K_STD = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] P_STD = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] C_STD = 128'h681edf34d206965e86b3e94f536e4246;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         cmd_valid_in, cmd_ready_out;
  logic [1:0]   cmd_op_in;
  logic [127:0] cmd_data_in;
  logic         rsp_valid_out, rsp_ready_in, rsp_err_out;
  logic [127:0] rsp_data_out;
  logic         key_loaded_out, busy_out, sm4_enable_out, encdec_sel_out;
  logic         enable_key_exp_out, user_key_valid_out, key_exp_ready_in;
  logic [127:0] user_key_out, data_out, result_in;
  logic         encdec_enable_out, valid_out, ready_in;
  logic [2:0]   fsm_state_out;

  int n_cmp = 0;
  int n_mis = 0;
  logic [128:0] exp_q[$];

  // reference view of the sequencer's key cache
  bit           m_loaded = 0;
  logic [127:0] m_key = '0;
  logic         m_mode = DIR_ENC;

  // core model state
  logic [127:0] core_key = '0;
  logic         core_sel = 1'b0;
  logic [127:0] core_pend = '0;
  int           kcnt = 0;
  int           bcnt = 0;
  bit           core_stuck = 0;

  // strobe monitors
  int   n_key = 0;
  int   n_blk = 0;
  logic last_sel = 1'b0;

  logic [520:0] all_out;
  assign all_out = {cmd_ready_out, rsp_valid_out, rsp_data_out, rsp_err_out, key_loaded_out,
                    busy_out, sm4_enable_out, encdec_sel_out, enable_key_exp_out,
                    user_key_valid_out, user_key_out, encdec_enable_out, valid_out,
                    data_out, fsm_state_out};

  sm4_cmd_sched #(.TIMEOUT_CYCLES(TB_TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
    .cmd_op_in(cmd_op_in), .cmd_data_in(cmd_data_in),
    .rsp_valid_out(rsp_valid_out), .rsp_ready_in(rsp_ready_in),
    .rsp_data_out(rsp_data_out), .rsp_err_out(rsp_err_out),
    .key_loaded_out(key_loaded_out), .busy_out(busy_out),
    .sm4_enable_out(sm4_enable_out), .encdec_sel_out(encdec_sel_out),
    .enable_key_exp_out(enable_key_exp_out), .user_key_valid_out(user_key_valid_out),
    .user_key_out(user_key_out), .key_exp_ready_in(key_exp_ready_in),
    .encdec_enable_out(encdec_enable_out), .valid_out(valid_out),
    .data_out(data_out), .ready_in(ready_in), .result_in(result_in),
    .fsm_state_out(fsm_state_out)
  );

  // clock
  always #5 clk = ~clk;

  // stand-in for the SM4 core: the standard vector is exact, anything else
  // uses an invertible keyed swap so enc/dec round-trips
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic dec,
                                           input logic [127:0] x);
    logic [127:0] t;
    if (k == K_STD && !dec && x == P_STD) return C_STD;
    if (k == K_STD && dec && x == C_STD) return P_STD;
    if (!dec) return {x[63:0], x[127:64]} ^ k;
    t = x ^ k;
    return {t[63:0], t[127:64]};
  endfunction

  // core model: ready levels are registered from the previous countdown, so
  // the first cycle after a strobe still shows the old (stale) level
  always @(negedge clk) begin
    bit kr_next, br_next, key_busy;
    key_busy = (kcnt != 0);
    kr_next  = (kcnt == 0);
    if (user_key_valid_out) begin
      core_key = user_key_out;
      core_sel = encdec_sel_out;
      kcnt = 3;
    end else if (kcnt != 0) begin
      kcnt--;
    end
    key_exp_ready_in = kr_next;
    br_next = (bcnt == 0);
    if (valid_out) begin
      core_pend = key_busy ? 128'hdead_dead_dead_dead_dead_dead_dead_dead
                           : core_fn(core_key, core_sel, data_out);
      result_in = 128'h0bad_0bad_0bad_0bad_0bad_0bad_0bad_0bad;
      bcnt = 3;
    end else if (bcnt != 0 && !core_stuck) begin
      bcnt--;
      if (bcnt == 0) result_in = core_pend;
    end
    ready_in = br_next;
  end

  // strobe counters
  always @(negedge clk) begin
    if (user_key_valid_out) begin
      n_key++;
      last_sel = encdec_sel_out;
    end
    if (valid_out) n_blk++;
  end

  task automatic send_cmd(input logic [1:0] op, input logic [127:0] data);
    bit ok;
    ok = 0;
    @(negedge clk);
    cmd_valid_in = 1'b1;
    cmd_op_in    = op;
    cmd_data_in  = data;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready_out === 1'b1) begin
        @(posedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    cmd_valid_in = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_mis++;
      $display("FAIL cmd_accept: cmd_ready_out never 1 within 200 cycles, required 1");
    end
  endtask

  task automatic recv_rsp(input string name);
    logic [128:0] exp;
    bit got;
    got = 0;
    exp = '0;
    @(negedge clk);
    rsp_ready_in = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (rsp_valid_out === 1'b1) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    if (exp_q.size() != 0) exp = exp_q.pop_front();
    n_cmp++;
    if (!got) begin
      n_mis++;
      $display("FAIL %s: no response within 400 cycles, required err=%b data=%h",
               name, exp[128], exp[127:0]);
    end else if ({rsp_err_out, rsp_data_out} !== exp) begin
      n_mis++;
      $display("FAIL %s: got err=%b data=%h, required err=%b data=%h",
               name, rsp_err_out, rsp_data_out, exp[128], exp[127:0]);
    end
    if (got) @(posedge clk);
    @(negedge clk);
    rsp_ready_in = 1'b0;
  endtask

  // full command: predict response and strobes, drive, collect, compare
  task automatic do_cmd(input logic [1:0] op, input logic [127:0] data);
    int k0, b0, exp_k, exp_b;
    logic exp_sel;
    k0 = n_key; b0 = n_blk; exp_k = 0; exp_b = 0; exp_sel = DIR_ENC;
    if (op == OP_LOAD_KEY) begin
      exp_q.push_back({1'b0, 128'h0});
      m_key = data; m_loaded = 1; m_mode = DIR_ENC;
      exp_k = 1;
    end else if (op == OP_RSVD || !m_loaded) begin
      exp_q.push_back({1'b1, 128'h0});
    end else begin
      if (m_mode != op_dir(op)) begin
        exp_k = 1; exp_sel = op_dir(op); m_mode = op_dir(op);
      end
      exp_b = 1;
      exp_q.push_back({1'b0, core_fn(m_key, op_dir(op), data)});
    end
    send_cmd(op, data);
    recv_rsp($sformatf("rsp_op%0d", op));
    n_cmp++;
    if (n_key - k0 !== exp_k) begin
      n_mis++;
      $display("FAIL key_pulses_op%0d: got %0d, required %0d", op, n_key - k0, exp_k);
    end
    n_cmp++;
    if (n_blk - b0 !== exp_b) begin
      n_mis++;
      $display("FAIL blk_pulses_op%0d: got %0d, required %0d", op, n_blk - b0, exp_b);
    end
    if (exp_k == 1) begin
      n_cmp++;
      if (last_sel !== exp_sel) begin
        n_mis++;
        $display("FAIL key_sel_op%0d: got %b, required %b", op, last_sel, exp_sel);
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ((|all_out) !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_outputs: got %h, required all zero", all_out);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({cmd_ready_out, sm4_enable_out, busy_out, key_loaded_out} !== 4'b1100) begin
      n_mis++;
      $display("FAIL post_reset_flags: got %b, required 1100",
               {cmd_ready_out, sm4_enable_out, busy_out, key_loaded_out});
    end
  endtask

  task automatic test_no_key;
    do_cmd(OP_ENC, P_STD);
    do_cmd(OP_RSVD, K_STD);
  endtask

  task automatic test_load_enc;
    do_cmd(OP_LOAD_KEY, K_STD);
    n_cmp++;
    if (key_loaded_out !== 1'b1 || user_key_out !== K_STD) begin
      n_mis++;
      $display("FAIL key_cached: got loaded=%b key=%h, required 1 %h",
               key_loaded_out, user_key_out, K_STD);
    end
    do_cmd(OP_ENC, P_STD);
  endtask

  task automatic test_rekey;
    do_cmd(OP_DEC, C_STD);
    do_cmd(OP_DEC, {$urandom, $urandom, $urandom, $urandom});
    n_cmp++;
    if (encdec_sel_out !== DIR_DEC) begin
      n_mis++;
      $display("FAIL idle_sel: got %b, required 1", encdec_sel_out);
    end
    do_cmd(OP_ENC, {$urandom, $urandom, $urandom, $urandom});
    do_cmd(OP_RSVD, 128'h1);
  endtask

  task automatic test_rsp_hold;
    logic [127:0] blk;
    logic [128:0] exp;
    bit got, bad;
    blk = {$urandom, $urandom, $urandom, $urandom};
    exp = {1'b0, core_fn(m_key, m_mode, blk)};
    exp_q.push_back(exp);
    send_cmd(m_mode == DIR_ENC ? OP_ENC : OP_DEC, blk);
    got = 0;
    for (int i = 0; i < 400; i++) begin
      if (rsp_valid_out === 1'b1) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (!got) begin
      n_mis++;
      $display("FAIL hold_rsp_seen: rsp_valid_out never 1, required 1");
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid_out !== 1'b1 || {rsp_err_out, rsp_data_out} !== exp ||
          cmd_ready_out !== 1'b0) begin
        if (!bad) $display("FAIL hold_stable: cycle %0d got v=%b err=%b data=%h rdy=%b, required 1 %b %h 0",
                           i, rsp_valid_out, rsp_err_out, rsp_data_out, cmd_ready_out,
                           exp[128], exp[127:0]);
        bad = 1;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (bad) n_mis++;
    recv_rsp("hold_rsp");
    do_cmd(OP_ENC, {$urandom, $urandom, $urandom, $urandom});
  endtask

  task automatic test_random;
    for (int i = 0; i < 10; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      do_cmd(op, {$urandom, $urandom, $urandom, $urandom});
    end
  endtask

`ifdef SM4_CMD_SCHED_WDOG_EN
  task automatic test_wdog;
    int wcnt;
    bit flushed;
    do_cmd(OP_LOAD_KEY, {$urandom, $urandom, $urandom, $urandom});
    core_stuck = 1;
    exp_q.push_back({1'b1, 128'h0});
    send_cmd(OP_ENC, 128'h5);
    wcnt = 0;
    flushed = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (fsm_state_out === ST_BLK_WAIT) wcnt++;
      else if (wcnt != 0) break;
    end
    n_cmp++;
    if (wcnt !== TB_TO) begin
      n_mis++;
      $display("FAIL wdog_cycles: got %0d wait cycles, required %0d", wcnt, TB_TO);
    end
    n_cmp++;
    if (fsm_state_out !== ST_FLUSH || sm4_enable_out !== 1'b0 ||
        {encdec_enable_out, valid_out, enable_key_exp_out, user_key_valid_out} !== 4'b0) begin
      n_mis++;
      $display("FAIL wdog_flush: got state=%0d en=%b strobes=%b, required 6 0 0000",
               fsm_state_out, sm4_enable_out,
               {encdec_enable_out, valid_out, enable_key_exp_out, user_key_valid_out});
    end
    m_loaded = 0;
    recv_rsp("wdog_rsp");
    n_cmp++;
    if (key_loaded_out !== 1'b0) begin
      n_mis++;
      $display("FAIL wdog_key_loaded: got %b, required 0", key_loaded_out);
    end
    core_stuck = 0;
    repeat (6) @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid;
    bit seen;
    do_cmd(OP_LOAD_KEY, {$urandom, $urandom, $urandom, $urandom});
    core_stuck = 1;
    send_cmd(OP_ENC, 128'h77);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      if (fsm_state_out === ST_BLK_WAIT) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (!seen) begin
      n_mis++;
      $display("FAIL mid_reach_blk_wait: got state %0d, required %0d", fsm_state_out, ST_BLK_WAIT);
    end
    #1 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ((|all_out) !== 1'b0) begin
      n_mis++;
      $display("FAIL mid_reset_async: got %h, required all zero", all_out);
    end
    core_stuck = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_loaded = 0; m_key = '0; m_mode = DIR_ENC;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid_out !== 1'b0) seen = 1;
    end
    n_cmp++;
    if (seen || key_loaded_out !== 1'b0 || user_key_out !== 128'h0) begin
      n_mis++;
      $display("FAIL mid_reset_after: got rsp_seen=%b loaded=%b key=%h, required 0 0 0",
               seen, key_loaded_out, user_key_out);
    end
    do_cmd(OP_DEC, 128'h99);
  endtask

  initial begin
    reset_n = 1'b0;
    cmd_valid_in = 1'b0;
    cmd_op_in = 2'b00;
    cmd_data_in = '0;
    rsp_ready_in = 1'b0;
    key_exp_ready_in = 1'b0;
    ready_in = 1'b0;
    result_in = '0;
    test_reset;
    test_no_key;
    test_load_enc;
    test_rekey;
    test_rsp_hold;
    test_random;
`ifdef SM4_CMD_SCHED_WDOG_EN
    test_wdog;
`endif
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
